alu_issue_stage: RTL
====================

# alu_issue_stage

Operand-issue and writeback stage wrapped around the combinational ALU. Accepts register-addressed instructions over a valid/ready handshake and reads operands from an internal register file, with forwarding of the in-flight ALU result. It drives the registered `A`/`B`/`s` inputs of the ALU, then writes the ALU result back one cycle later and maintains a sticky overflow flag and a retire counter.

## Interface
- `DW`, 32, data width; must match ALU width.
- `NREG`, 8, register count; power of two. `AW = log2(NREG)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  instruction accepted when `in_valid && in_ready`.
- `in_op`  in  3  ALU select code.
- `in_rd`, `in_rs1`, `in_rs2`  in  AW each  destination register and source registers.
- `ld_valid`  in  1  direct register load (initialisation port).
- `ld_rd`  in  AW  load target.
- `ld_data`  in  DW  load value.
- `hold`  in  1  freezes the whole pipeline.
- `alu_a`, `alu_b`  out  DW  registered ALU operands.
- `alu_s`  out  3  registered ALU select.
- `alu_result`  in  DW  combinational ALU result.
- `alu_overflow`  in  1  ALU overflow.
- `wb_valid`  out  1  one-cycle pulse per retired instruction.
- `wb_rd`  out  AW  register written.
- `wb_data`  out  DW  value written.
- `ovf_sticky`  out  1  set by any retired arithmetic overflow.
- `ovf_clr`  in  1  clears `ovf_sticky`.
- `retire_cnt`  out  16  count of retired instructions; wraps.

## Operation
- `in_ready = !hold && !ld_valid`. A load always takes priority over issue.
- Issue (accept cycle):
  - Read `rs1` and `rs2`. `r0` always reads 0.
  - Forwarding: if `ex_valid` and `ex_rd == rsN` and `rsN != 0`, the operand is `alu_result` instead of the register file value.
  - Latch `alu_a`, `alu_b`, `alu_s <= in_op`, `ex_rd <= in_rd`, `ex_valid <= 1`.
  - With no accept and no hold, `ex_valid <= 0`. `alu_a`, `alu_b` and `alu_s` keep their last values.
- Execute/writeback, at the edge ending a cycle with `ex_valid && !hold`:
  - `regfile[ex_rd] <= alu_result`; writes to `r0` are discarded.
  - `wb_valid <= 1`, `wb_rd <= ex_rd`, `wb_data <= alu_result`. `wb_data` carries the ALU value even when `rd == 0`.
  - `retire_cnt <= retire_cnt + 1`, modulo 2^16.
  - If `alu_s[2] == 1` (codes 100–111) and `alu_overflow` is high, `ovf_sticky <= 1`.
  - `alu_overflow` is ignored for logic codes 000–011, because the ALU does not define it there.
- `wb_valid` is 0 in any cycle that does not follow a retire.
- Loads: `ld_valid` writes `ld_data` to `ld_rd` (unless `ld_rd == 0`).
  - If a load and a writeback target the same register on the same edge, the writeback wins.
  - A load does not clear `ex_valid`; an instruction already in EX still retires on that edge.
- `ovf_clr`: clears `ovf_sticky`. On the same edge as a set, the set wins.
- `hold`: no issue, EX registers frozen, no writeback, `wb_valid <= 0`. Forwarding remains active, so an instruction waiting at issue sees a consistent value after release.

## Timing
- Reset values: every register file entry 0; `ex_valid` 0; `alu_a`, `alu_b`, `alu_s`, `ex_rd` 0; `wb_valid` 0; `wb_rd`, `wb_data` 0; `ovf_sticky` 0; `retire_cnt` 0.
- `rst` asserted mid-operation: the in-flight instruction is dropped with no writeback.
- Latency: accept at edge N, operands on the ALU during cycle N+1, register written at edge N+1, `wb_valid` high during cycle N+2.
- Throughput: one instruction per cycle.
- Back-to-back dependent instructions need no stall; the forwarding path covers a distance of 1. A distance of 2 or more reads the register file, which is already updated.
- Critical path: ALU → forward mux → `alu_a`/`alu_b` registers.

## Structure
- Shared package `alu_pkg` holds:
  - ALU opcode constants `OP_NOT`=000, `OP_AND`, `OP_XOR`, `OP_OR`, `OP_DEC`=100, `OP_ADD`, `OP_SUB`, `OP_INC`=111.
  - `DW` and the `is_arith(op)` helper, equivalent to `op[2]`.
- Sub-module `alu_regfile`: NREG×DW, two combinational read ports, two write ports (writeback priority over load), `r0` hardwired to zero, asynchronous reset.
- Forwarding, handshake and counters live in the top level.

## Test plan
- Load r1=5, r2=3; issue ADD r3,r1,r2 → `alu_a`=5, `alu_b`=3, `alu_s`=101 in the next cycle; `wb_valid` with `wb_rd`=3, `wb_data`=8 one cycle later; `retire_cnt`=1.
- Dependent chain: ADD r3,r1,r2 then SUB r4,r3,r1 on consecutive cycles → second `alu_a`=8 (forwarded); r4=3.
- r1=0x7FFFFFFF, INC r5,r1 → `wb_data`=0x80000000 and `ovf_sticky`=1. AND r6,r1,r1 with a stale `alu_overflow` → no effect on `ovf_sticky`. `ovf_clr` on the same cycle as a new overflow → flag stays 1.
- `hold` asserted while ADD is in EX for 3 cycles → `in_ready`=0, no `wb_valid`, operands stable. After release, the writeback occurs exactly once.
- `ld_valid` to r3 on the same edge as an EX write to r3 → r3 holds the ALU result. `in_ready`=0 during the load.
- Write to r0 → `wb_valid` pulses; a later read of r0 returns 0. `rst` mid-instruction → all outputs 0, no writeback. 65536 retires → `retire_cnt` wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, width and arithmetic-class helper
package alu_pkg;
    localparam int DW = 32;

    typedef enum logic [2:0] {
        OP_NOT = 3'b000,
        OP_AND = 3'b001,
        OP_XOR = 3'b010,
        OP_OR  = 3'b011,
        OP_DEC = 3'b100,
        OP_ADD = 3'b101,
        OP_SUB = 3'b110,
        OP_INC = 3'b111
    } alu_op_e;

    function automatic logic is_arith(input logic [2:0] op);
        return op[2];
    endfunction
endpackage

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - instruction issue handshake bundle
interface alu_issue_stage_if #(
    parameter int AW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;

    modport master (output in_valid, in_op, in_rd, in_rs1, in_rs2, input in_ready);
    modport slave  (input in_valid, in_op, in_rd, in_rs1, in_rs2, output in_ready);
endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREG x DW register file, two async read ports, r0 reads zero
module alu_regfile #(
    parameter  int DW   = 32,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_rd_addr0,
    output logic [DW-1:0] o_rd_data0,
    input  logic [AW-1:0] i_rd_addr1,
    output logic [DW-1:0] o_rd_data1,
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [DW-1:0] i_wb_data,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [DW-1:0] i_ld_data
);
    logic [DW-1:0] r_mem [NREG];

    // Entry 0 is never written; writeback beats a load to the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (i_wb_en && i_wb_addr == AW'(i))
                    r_mem[i] <= i_wb_data;
                else if (i_ld_en && i_ld_addr == AW'(i))
                    r_mem[i] <= i_ld_data;
            end
        end
    end

    assign o_rd_data0 = (i_rd_addr0 == '0) ? '0 : r_mem[i_rd_addr0];
    assign o_rd_data1 = (i_rd_addr1 == '0) ? '0 : r_mem[i_rd_addr1];
endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand issue, forwarding and writeback around a combinational ALU
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter  int DW   = alu_pkg::DW,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_stage_if.slave issue,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_rd,
    input  logic [DW-1:0]   ld_data,
    input  logic            hold,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [2:0]      alu_s,
    input  logic [DW-1:0]   alu_result,
    input  logic            alu_overflow,
    output logic            wb_valid,
    output logic [AW-1:0]   wb_rd,
    output logic [DW-1:0]   wb_data,
    output logic            ovf_sticky,
    input  logic            ovf_clr,
    output logic [15:0]     retire_cnt
);
    logic [DW-1:0] w_rf_a, w_rf_b, w_op_a, w_op_b;
    logic          w_accept, w_retire, w_fwd_a, w_fwd_b, w_ovf_set;

    logic          r_ex_valid;
    logic [AW-1:0] r_ex_rd;
    logic [DW-1:0] r_alu_a, r_alu_b;
    logic [2:0]    r_alu_s;
    logic          r_wb_valid;
    logic [AW-1:0] r_wb_rd;
    logic [DW-1:0] r_wb_data;
    logic          r_ovf_sticky;
    logic [15:0]   r_retire_cnt;

    assign issue.in_ready = !hold && !ld_valid;
    assign w_accept       = issue.in_valid && !hold && !ld_valid;
    assign w_retire       = r_ex_valid && !hold;

    // Distance-1 dependency: the value being written this edge is still only on the ALU output.
    assign w_fwd_a = r_ex_valid && (r_ex_rd == issue.in_rs1) && (issue.in_rs1 != '0);
    assign w_fwd_b = r_ex_valid && (r_ex_rd == issue.in_rs2) && (issue.in_rs2 != '0);
    assign w_op_a  = w_fwd_a ? alu_result : w_rf_a;
    assign w_op_b  = w_fwd_b ? alu_result : w_rf_b;

    assign w_ovf_set = w_retire && is_arith(r_alu_s) && alu_overflow;

    alu_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_rd_addr0 (issue.in_rs1),
        .o_rd_data0 (w_rf_a),
        .i_rd_addr1 (issue.in_rs2),
        .o_rd_data1 (w_rf_b),
        .i_wb_en    (w_retire),
        .i_wb_addr  (r_ex_rd),
        .i_wb_data  (alu_result),
        .i_ld_en    (ld_valid),
        .i_ld_addr  (ld_rd),
        .i_ld_data  (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_s    <= '0;
        end else if (!hold) begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_rd <= issue.in_rd;
                r_alu_a <= w_op_a;
                r_alu_b <= w_op_b;
                r_alu_s <= issue.in_op;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_retire_cnt <= '0;
            r_ovf_sticky <= 1'b0;
        end else begin
            r_wb_valid <= w_retire;
            if (w_retire) begin
                r_wb_rd      <= r_ex_rd;
                r_wb_data    <= alu_result;
                r_retire_cnt <= r_retire_cnt + 16'd1;
            end
            if (w_ovf_set)
                r_ovf_sticky <= 1'b1;
            else if (ovf_clr)
                r_ovf_sticky <= 1'b0;
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_s      = r_alu_s;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign ovf_sticky = r_ovf_sticky;
    assign retire_cnt = r_retire_cnt;
endmodule
